fc_param_loader: RTL and testbench

Streams the parameters of one `fully_connected` layer from a byte-wide valid/ready source and assembles them into the flat `weights_in`/`biases_in` buses that the layer consumes. It issues the single-cycle `load_weights` and `load_biases` strobes that make the layer capture them. The block sits between the parameter memory/DMA path and each FC layer instance, and is the writer side of the layer's parameter-load interface.

---
 rtl/fc_param_loader_if.sv | 24 ++
 rtl/fc_param_loader.sv | 143 ++++++++++++++
 tb/tb_fc_param_loader.sv | 230 +++++++++++++++++++++++
 3 files changed

// File: rtl/fc_param_loader_if.sv
// Byte-wide valid/ready parameter stream feeding fc_param_loader.
// The source drives data, valid and last. The loader drives ready.
interface fc_param_loader_if #(
    parameter int ACTIV_BITS = 8
);
    logic [ACTIV_BITS-1:0] s_data;
    logic                  s_valid;
    logic                  s_last;
    logic                  s_ready;

    modport master (
        output s_data,
        output s_valid,
        output s_last,
        input  s_ready
    );

    modport slave (
        input  s_data,
        input  s_valid,
        input  s_last,
        output s_ready
    );
endinterface

// File: rtl/fc_param_loader.sv
// Loads one fully_connected layer's weights and biases from a byte stream.
// Each frame carries all weights first, then all biases, and s_last marks
// the final bias. The assembled buses are the staging registers themselves.
// A one-cycle load strobe follows each segment, so the layer captures the
// segment as soon as it is complete.
module fc_param_loader #(
    parameter int INPUT_SIZE  = 512,
    parameter int OUTPUT_SIZE = 128,
    parameter int ACTIV_BITS  = 8
) (
    input  logic                                       clk,
    input  logic                                       rst_n,
    input  logic                                       start,
    fc_param_loader_if.slave                           strm,
    output logic [OUTPUT_SIZE*INPUT_SIZE*ACTIV_BITS-1:0] weights_out,
    output logic [OUTPUT_SIZE*ACTIV_BITS-1:0]            biases_out,
    output logic                                       load_weights,
    output logic                                       load_biases,
    output logic                                       busy,
    output logic                                       done,
    output logic                                       err
);

    localparam int NW    = OUTPUT_SIZE * INPUT_SIZE;
    localparam int NB    = OUTPUT_SIZE;
    localparam int CNT_W = (NW > 1) ? $clog2(NW) : 1;

    // Biases never outnumber weights, so one counter covers both segments.
    localparam logic [CNT_W-1:0] LAST_W = CNT_W'(NW - 1);
    localparam logic [CNT_W-1:0] LAST_B = CNT_W'(NB - 1);

    typedef enum logic [2:0] {
        IDLE,
        WEIGHTS,
        W_COMMIT,
        BIASES,
        B_COMMIT
    } state_t;

    state_t           state, state_nx;
    logic [CNT_W-1:0] cnt, cnt_nx;
    logic             err_q, err_nx;
    logic             ready;
    logic             accept;

    // Everything the layer sees is decoded from the registered state only.
    assign ready        = (state == WEIGHTS) || (state == BIASES);
    assign strm.s_ready = ready;
    assign accept       = strm.s_valid && ready;
    assign load_weights = (state == W_COMMIT);
    assign load_biases  = (state == B_COMMIT);
    assign done         = (state == B_COMMIT);
    assign busy         = (state != IDLE);
    assign err          = err_q;

    // State, word counter and error pulse registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            cnt   <= '0;
            err_q <= 1'b0;
        end else begin
            state <= state_nx;
            cnt   <= cnt_nx;
            err_q <= err_nx;
        end
    end

    // Frame sequencing. A misplaced s_last aborts to IDLE without a strobe.
    always_comb begin
        state_nx = state;
        cnt_nx   = cnt;
        err_nx   = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    state_nx = WEIGHTS;
                    cnt_nx   = '0;
                end
            end
            WEIGHTS: begin
                if (accept) begin
                    cnt_nx = cnt + 1'b1;
                    if (strm.s_last) begin
                        state_nx = IDLE;
                        err_nx   = 1'b1;
                        cnt_nx   = '0;
                    end else if (cnt == LAST_W) begin
                        state_nx = W_COMMIT;
                    end
                end
            end
            W_COMMIT: begin
                state_nx = BIASES;
                cnt_nx   = '0;
            end
            BIASES: begin
                if (accept) begin
                    cnt_nx = cnt + 1'b1;
                    if (cnt == LAST_B) begin
                        if (strm.s_last) begin
                            state_nx = B_COMMIT;
                        end else begin
                            state_nx = IDLE;
                            err_nx   = 1'b1;
                            cnt_nx   = '0;
                        end
                    end else if (strm.s_last) begin
                        state_nx = IDLE;
                        err_nx   = 1'b1;
                        cnt_nx   = '0;
                    end
                end
            end
            B_COMMIT: begin
                state_nx = IDLE;
                cnt_nx   = '0;
            end
            default: begin
                state_nx = IDLE;
                cnt_nx   = '0;
            end
        endcase
    end

    // Write each accepted word into its slot and leave every other slot as it was.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            weights_out <= '0;
            biases_out  <= '0;
        end else if (accept) begin
            for (int k = 0; k < NW; k++) begin
                if (state == WEIGHTS && cnt == CNT_W'(k))
                    weights_out[k*ACTIV_BITS +: ACTIV_BITS] <= strm.s_data;
            end
            for (int i = 0; i < NB; i++) begin
                if (state == BIASES && cnt == CNT_W'(i))
                    biases_out[i*ACTIV_BITS +: ACTIV_BITS] <= strm.s_data;
            end
        end
    end

endmodule

// File: tb/tb_fc_param_loader.sv
// Directed bench for fc_param_loader with INPUT_SIZE=4, OUTPUT_SIZE=2 and
// ACTIV_BITS=8. Each stimulus task pushes the strobe event it expects, with
// its cycle stamp, into a queue. A negedge monitor pops one entry for every
// cycle in which any strobe, done or err is high and compares it.
module tb_fc_param_loader;

    localparam int IS = 4;
    localparam int OS = 2;
    localparam int AB = 8;

    typedef struct {
        logic [3:0]  flags;  // {load_weights, load_biases, done, err}
        int          cyc;
        logic [63:0] data;
    } ev_t;

    logic                  clk = 1'b0;
    logic                  rst_n = 1'b0;
    logic                  start = 1'b0;
    logic [OS*IS*AB-1:0]   weights_out;
    logic [OS*AB-1:0]      biases_out;
    logic                  load_weights, load_biases, busy, done, err;

    int  cyc = 0;
    int  n_chk = 0;
    int  n_fail = 0;
    int  start_cyc = 0;
    ev_t exp_q[$];
    ev_t mon_e;
    logic [3:0] mon_obs;

    fc_param_loader_if #(.ACTIV_BITS(AB)) strm ();

    fc_param_loader #(
        .INPUT_SIZE (IS),
        .OUTPUT_SIZE(OS),
        .ACTIV_BITS (AB)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (start),
        .strm        (strm),
        .weights_out (weights_out),
        .biases_out  (biases_out),
        .load_weights(load_weights),
        .load_biases (load_biases),
        .busy        (busy),
        .done        (done),
        .err         (err)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: actual 0x%0h required 0x%0h", name, act, exp);
        end
    endtask

    // Monitor: every cycle with a strobe, done or err must match the next expected event.
    always @(negedge clk) begin
        if (rst_n) begin
            mon_obs = {load_weights, load_biases, done, err};
            if (mon_obs != 4'b0000) begin
                if (exp_q.size() == 0) begin
                    n_chk++;
                    n_fail++;
                    $display("FAIL unexpected_event: actual flags 0x%0h at cycle %0d, required none",
                             mon_obs, cyc);
                end else begin
                    mon_e = exp_q.pop_front();
                    chk("event_flags", 64'(mon_obs), 64'(mon_e.flags));
                    chk("event_cycle", 64'(cyc), 64'(mon_e.cyc));
                    if (mon_e.flags[3]) chk("weights_out", weights_out, mon_e.data);
                    if (mon_e.flags[2]) chk("biases_out", 64'(biases_out), mon_e.data);
                end
            end
        end
    end

    task automatic push_ev(input logic [3:0] f, input int c, input logic [63:0] d);
        ev_t e;
        e.flags = f;
        e.cyc   = c;
        e.data  = d;
        exp_q.push_back(e);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Present one word (after an optional idle cycle) until the DUT accepts it.
    task automatic put_word(input logic [7:0] d, input logic last, input bit gap, output int acc_cyc);
        bit acc;
        int n;
        if (gap) begin
            strm.s_valid = 1'b0;
            step();
        end
        strm.s_data  = d;
        strm.s_last  = last;
        strm.s_valid = 1'b1;
        acc = 1'b0;
        n   = 0;
        while (!acc && n < 50) begin
            @(negedge clk);
            acc = strm.s_ready;
            step();
            n++;
        end
        strm.s_valid = 1'b0;
        strm.s_last  = 1'b0;
        acc_cyc = cyc;
        if (!acc) begin
            n_chk++;
            n_fail++;
            $display("FAIL accept_timeout: actual no accept of 0x%0h, required accept within 50 cycles", d);
        end
    endtask

    task automatic do_start();
        int n;
        n = 0;
        while (busy && n < 50) begin
            step();
            n++;
        end
        start = 1'b1;
        step();
        start = 1'b0;
        start_cyc = cyc;
        chk("busy_after_start", 64'(busy), 64'd1);
        chk("s_ready_after_start", 64'(strm.s_ready), 64'd1);
    endtask

    // One frame of weights 0x01..0x08 then biases 0x80, 0x7F.
    // err_w >= 0 puts s_last on that weight index; miss_last drops the final s_last.
    task automatic run_frame(input bit bp, input int err_w, input bit miss_last, input bit start_mid);
        int ac;
        do_start();
        for (int k = 0; k < IS*OS; k++) begin
            if (start_mid && k == 2) start = 1'b1;
            put_word(8'(k + 1), (k == err_w), bp && (k > 0), ac);
            start = 1'b0;
            if (k == err_w) begin
                push_ev(4'b0001, ac, 64'd0);
                chk("busy_after_err", 64'(busy), 64'd0);
                chk("s_ready_after_err", 64'(strm.s_ready), 64'd0);
                return;
            end
        end
        push_ev(4'b1000, ac, 64'h0807060504030201);
        put_word(8'h80, 1'b0, 1'b0, ac);
        put_word(8'h7F, !miss_last, bp, ac);
        if (miss_last) begin
            push_ev(4'b0001, ac, 64'd0);
        end else begin
            push_ev(4'b0110, ac, 64'h7F80);
            chk("frame_cycles", 64'(ac - start_cyc + 1), bp ? 64'd20 : 64'd12);
        end
        if (start_mid) begin
            start = 1'b1;
            step();
            start = 1'b0;
            for (int c = 0; c < 3; c++) begin
                chk("s_ready_after_done", 64'(strm.s_ready), 64'd0);
                chk("busy_after_done", 64'(busy), 64'd0);
                step();
            end
        end
    endtask

    task automatic chk_cleared(input string tag);
        chk({tag, "_weights"}, weights_out, 64'd0);
        chk({tag, "_biases"}, 64'(biases_out), 64'd0);
        chk({tag, "_ready"}, 64'(strm.s_ready), 64'd0);
        chk({tag, "_busy"}, 64'(busy), 64'd0);
        chk({tag, "_strobes"}, 64'({load_weights, load_biases, done, err}), 64'd0);
    endtask

    initial begin
        int ac;
        strm.s_data  = '0;
        strm.s_valid = 1'b0;
        strm.s_last  = 1'b0;
        #1;
        chk_cleared("reset");
        repeat (3) step();
        rst_n = 1'b1;
        step();

        run_frame(1'b0, -1, 1'b0, 1'b0);   // nominal
        run_frame(1'b1, -1, 1'b0, 1'b0);   // backpressure
        run_frame(1'b0, 4, 1'b0, 1'b0);    // early s_last on word 0x05
        run_frame(1'b0, -1, 1'b0, 1'b0);   // recovery
        run_frame(1'b0, -1, 1'b1, 1'b0);   // missing final s_last

        // Reset mid-frame after three weight words.
        do_start();
        for (int k = 0; k < 3; k++) put_word(8'(k + 1), 1'b0, 1'b0, ac);
        rst_n = 1'b0;
        #2;
        chk_cleared("midreset");
        step();
        step();
        rst_n = 1'b1;
        step();
        run_frame(1'b0, -1, 1'b0, 1'b0);   // recovery after reset

        run_frame(1'b0, -1, 1'b0, 1'b1);   // start pulses in WEIGHTS and B_COMMIT

        repeat (5) step();
        chk("pending_events", 64'(exp_q.size()), 64'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: actual simulation still running, required completion");
        $fatal(1, "watchdog");
    end

endmodule
